dp_act_sequencer: RTL

DP_ACT_SEQUENCER -- requirements
Module: dp_act_sequencer

---
 rtl/dp_pkg.sv | 8 +
 rtl/nz_compactor.sv | 23 ++
 rtl/dp_act_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared sizes and FSM state type for the dot-product activation sequencer.
package dp_pkg;
  localparam int BW = 4;
  localparam int N = 4;
  localparam int PSUM_BW = 20;
  localparam int IDX_W = 2;
  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;
endpackage

// File: rtl/nz_compactor.sv
// nz_compactor: ascending list of element indices to issue, plus their count.
module nz_compactor
  import dp_pkg::*;
#(
  parameter int bw = BW,
  parameter int n = N,
  parameter bit skip_zero = 1'b1
) (
  input  logic [n*bw-1:0]            act_dense_i,
  output logic [n-1:0][IDX_W-1:0]    idx_list_o,
  output logic [IDX_W:0]             nz_o
);
  always_comb begin
    idx_list_o = '0;
    nz_o = '0;
    for (int k = 0; k < n; k++) begin
      if (!skip_zero || act_dense_i[k*bw +: bw] != '0) begin
        idx_list_o[nz_o[IDX_W-1:0]] = IDX_W'(k);
        nz_o = nz_o + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dp_act_sequencer.sv
// dp_act_sequencer: issues a dense activation vector to a two-slot dot-product PE as index/value pairs.
module dp_act_sequencer
  import dp_pkg::*;
#(
  parameter int bw = BW,
  parameter int n = N,
  parameter int psum_bw = PSUM_BW,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [n*bw-1:0]      act_dense,
  input  logic [psum_bw-1:0]   psum_init,
  output logic [2*bw-1:0]      activation_flat,
  output logic [2*IDX_W-1:0]   activation_index_flat,
  output logic                 a_select,
  output logic                 load,
  output logic                 execute,
  output logic [psum_bw-1:0]   psum_to_pe,
  output logic                 done
);
  state_t state_q, state_d;
  logic sel_q, sel_d, cnt_q, cnt_d;
  logic [n*bw-1:0] act_q, act_d;
  logic [n-1:0][IDX_W-1:0] idx_q, idx_d, idx_c;
  logic [IDX_W:0] nz_q, nz_d, nz_c;
  logic rdy_q, rdy_d, asel_q, asel_d, load_q, load_d, exec_q, exec_d, done_q, done_d;
  logic [2*bw-1:0] af_q, af_d;
  logic [2*IDX_W-1:0] ix_q, ix_d;
  logic [psum_bw-1:0] ps_q, ps_d;
  logic hs, last_pair, issue_d, v0, v1;
  logic [IDX_W-1:0] e0, e1, i0, i1;
  logic [bw-1:0] a0, a1;

  nz_compactor #(.bw(bw), .n(n), .skip_zero(SKIP_ZERO)) u_cmp (
    .act_dense_i (act_dense),
    .idx_list_o  (idx_c),
    .nz_o        (nz_c)
  );

  assign hs = in_valid & rdy_q;
  // two entries per pair, so the last pair index is 1 once more than two entries exist
  assign last_pair = nz_q > 3'd2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      cnt_q <= 1'b0;
      act_q <= '0;
      idx_q <= '0;
      nz_q <= '0;
      rdy_q <= 1'b1;
      asel_q <= 1'b0;
      load_q <= 1'b0;
      exec_q <= 1'b0;
      done_q <= 1'b0;
      af_q <= '0;
      ix_q <= '0;
      ps_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
      idx_q <= idx_d;
      nz_q <= nz_d;
      rdy_q <= rdy_d;
      asel_q <= asel_d;
      load_q <= load_d;
      exec_q <= exec_d;
      done_q <= done_d;
      af_q <= af_d;
      ix_q <= ix_d;
      ps_q <= ps_d;
    end
  end

  always_comb begin
    state_d = (state_q == IDLE)  ? (hs ? LOAD : IDLE) :
              (state_q == LOAD)  ? ((nz_q != '0) ? ISSUE : DONE) :
              (state_q == ISSUE) ? ((sel_q && cnt_q == last_pair) ? DONE : ISSUE) : IDLE;
    sel_d = (state_q == ISSUE) & ~sel_q;
    cnt_d = (state_q != ISSUE) ? 1'b0 : (sel_q && cnt_q != last_pair) ? cnt_q + 1'b1 : cnt_q;
    act_d = hs ? act_dense : act_q;
    idx_d = hs ? idx_c : idx_q;
    nz_d = hs ? nz_c : nz_q;
  end

  // outputs are registered from next-state values so they line up with the state they describe
  always_comb begin
    issue_d = state_d == ISSUE;
    e0 = {cnt_d, 1'b0};
    e1 = {cnt_d, 1'b1};
    v0 = {1'b0, e0} < nz_q;
    v1 = {1'b0, e1} < nz_q;
    i0 = v0 ? idx_q[e0] : '0;
    i1 = v1 ? idx_q[e1] : '0;
    a0 = v0 ? act_q[i0*bw +: bw] : '0;
    a1 = v1 ? act_q[i1*bw +: bw] : '0;
    af_d = issue_d ? {a1, a0} : '0;
    ix_d = issue_d ? {i1, i0} : '0;
    asel_d = issue_d & sel_d;
    load_d = state_d == LOAD;
    exec_d = (state_d == LOAD) | issue_d;
    done_d = state_d == DONE;
    rdy_d = state_d == IDLE;
    ps_d = (state_d == LOAD) ? psum_init : '0;
  end

  assign in_ready = rdy_q;
  assign activation_flat = af_q;
  assign activation_index_flat = ix_q;
  assign a_select = asel_q;
  assign load = load_q;
  assign execute = exec_q;
  assign psum_to_pe = ps_q;
  assign done = done_q;
endmodule
